tick_gen_multi: RTL and testbench
=================================

TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter OUT_FREQ, default 9600, meaning reset-time tick rate of every channel.
REQ-003 The block SHALL have parameter NUM_CH, default 4, meaning number of independent tick channels (1..16).
REQ-004 The block SHALL have parameter DIV_WIDTH, default 24, meaning width of the runtime divisor.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-007 The block SHALL have port sync, input, 1, meaning restart the phase of all running channels.
REQ-008 The block SHALL have port cfg_valid, input, 1, meaning a configuration request is present.
REQ-009 The block SHALL have port cfg_ready, output, 1, meaning the block can accept a configuration this cycle.
REQ-010 The block SHALL have port cfg_ch, input, 4, meaning target channel index.
REQ-011 The block SHALL have port cfg_div, input, DIV_WIDTH, meaning period in clk cycles.
REQ-012 The block SHALL have port cfg_mode, input, 2, meaning OFF=0, PERIODIC=1, ONESHOT=2, reserved 3 treated as OFF.
REQ-013 The block SHALL have port tick, output, NUM_CH, meaning one-cycle registered pulse per channel.
REQ-014 The block SHALL have port busy, output, NUM_CH, meaning channel is in ONESHOT awaiting its pulse.
REQ-015 The block SHALL have port cfg_err, output, 1, meaning one-cycle pulse when an accepted request was rejected.

Function
REQ-016 Accept SHALL occur on a rising edge where cfg_valid and cfg_ready are both 1.
REQ-017 cfg_ready SHALL be 0 for exactly the cycle following an accept and 1 otherwise; at most one accept per two cycles.
REQ-018 On accept at edge A, the addressed channel SHALL load mode and divisor, clear its counter to 0 and drive tick low at edge A.
REQ-019 Each channel SHALL hold a counter counting 0..div-1; at the edge where the counter equals div-1 in PERIODIC/ONESHOT, tick SHALL go high for one cycle and the counter SHALL wrap to 0.
REQ-020 First tick after a (re)start at edge S SHALL be high during the div-th cycle after S, giving exactly div cycles between consecutive ticks; div=1 yields tick high every cycle.
REQ-021 ONESHOT SHALL emit exactly one tick, then enter OFF at the same edge; busy SHALL be 1 from accept until that edge and 0 while tick is high.
REQ-022 OFF SHALL hold the counter at 0, tick 0, busy 0.
REQ-023 An accepted request with cfg_div=0 or cfg_ch>=NUM_CH SHALL leave all channels unchanged and pulse cfg_err the cycle after accept.
REQ-024 sync=1 at an edge SHALL clear every non-OFF channel's counter to 0 and force its tick to 0, without changing mode.
REQ-025 sync and accept at the same edge SHALL both apply; the addressed channel takes the new configuration, the others restart phase.
REQ-026 Re-configuring a channel mid-period SHALL discard the partial period; no tick SHALL be emitted for it.
REQ-027 Counter and divisor comparison SHALL be DIV_WIDTH bits unsigned; no overflow is possible since div-1 fits DIV_WIDTH.

Reset
REQ-028 While rst_n=0 at an edge: every channel SHALL be PERIODIC with div=DEFAULT_DIV=CLK_FREQ/OUT_FREQ, counter 0; tick=0, busy=0, cfg_err=0, cfg_ready=1.
REQ-029 Reset asserted mid-period or mid-ONESHOT SHALL abandon it; first tick after release follows REQ-020 with S = first edge with rst_n=1.
REQ-030 DEFAULT_DIV SHALL be >=1 and fit DIV_WIDTH; violation SHALL be an elaboration-time error.

Structure
REQ-031 Shared package tick_gen_pkg SHALL hold the mode enum (OFF/PERIODIC/ONESHOT) and the cfg_mode decode.
REQ-032 Per-channel counter and mode state SHALL be one sub-module tick_channel, instantiated NUM_CH times by generate; handshake, decode and error logic stay in the top.

Verification (CLK_FREQ=100, OUT_FREQ=10, NUM_CH=4, DIV_WIDTH=8)
REQ-033 Release reset, no config -> all four tick bits high in cycles 10, 20, 30 after release, low elsewhere.
REQ-034 Accept ch1 PERIODIC div=3 at edge A -> tick[1] high cycles A+3, A+6, A+9; cfg_ready low cycle A+1; other channels undisturbed.
REQ-035 Accept ch2 ONESHOT div=5 -> busy[2] high 4 cycles, tick[2] once at A+5, then tick[2]/busy[2] stay 0 for 50 cycles.
REQ-036 Accept ch7 or div=0 -> cfg_err high one cycle; all tick patterns unchanged.
REQ-037 sync at cycle 4 after reset -> all ticks next at cycle 14; sync plus ch0 div=2 accept same edge -> ch0 ticks every 2, others restart at 10.
REQ-038 rst_n low 3 cycles during ONESHOT div=20 on ch3 -> no ch3 pulse; ch3 resumes PERIODIC div=10 after release.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel modes and
// the decode of the raw configuration mode field.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2
  } mode_e;

  // The reserved encoding 3 behaves as OFF.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_PERIODIC;
      2'd2:    return MODE_ONESHOT;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: holds mode, divisor and phase counter, and emits a
// registered one-cycle tick once every div cycles.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int                   DIV_WIDTH   = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = {{(DIV_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 load,
  input  logic [1:0]           load_mode,
  input  logic [DIV_WIDTH-1:0] load_div,
  output logic                 tick,
  output logic                 busy
);

  localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  mode_e                mode_q, mode_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic [DIV_WIDTH-1:0] div_last;
  logic [DIV_WIDTH-1:0] cnt_step;
  logic                 fire;

  // The tick is registered together with the counter reaching div-1, so it is
  // high during the div-th cycle after a restart; the counter wraps afterwards.
  always_comb begin
    div_last = div_q - ONE;
    cnt_step = (cnt_q == div_last) ? '0 : cnt_q + ONE;
    fire     = (cnt_step == div_last);
    mode_d   = mode_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (load) begin
      mode_d = mode_e'(load_mode);
      div_d  = load_div;
      cnt_d  = '0;
    end else if (mode_q == MODE_OFF || restart) begin
      cnt_d = '0;
    end else begin
      cnt_d  = cnt_step;
      tick_d = fire;
      if (fire && mode_q == MODE_ONESHOT) begin
        mode_d = MODE_OFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_PERIODIC;
      div_q  <= DEFAULT_DIV;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
  assign busy = (mode_q == MODE_ONESHOT);

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: configuration handshake, request validation and
// global phase sync in front of NUM_CH independent tick channels.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int OUT_FREQ  = 9600,
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_mode,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    busy,
  output logic                 cfg_err
);

  localparam int                   DEFAULT_DIV_INT = CLK_FREQ / OUT_FREQ;
  localparam longint               DIV_MAX         = (longint'(1) << DIV_WIDTH) - 1;
  localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV     = DIV_WIDTH'(DEFAULT_DIV_INT);

  if (DEFAULT_DIV_INT < 1 || longint'(DEFAULT_DIV_INT) > DIV_MAX) begin : g_bad_default_div
    $error("tick_gen_multi: CLK_FREQ/OUT_FREQ must be >= 1 and fit DIV_WIDTH bits");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("tick_gen_multi: NUM_CH must be in 1..16");
  end

  logic       ready_q, ready_d;
  logic       err_q, err_d;
  logic       init_q, init_d;
  logic       accept;
  logic       cfg_bad;
  logic       load_ok;
  logic       restart;
  logic [1:0] load_mode;

  // init_q marks the first edge after reset release so every channel restarts
  // its phase there, exactly like a sync.
  always_comb begin
    accept    = cfg_valid && ready_q;
    cfg_bad   = (cfg_div == '0) || (int'(cfg_ch) >= NUM_CH);
    load_ok   = accept && !cfg_bad;
    restart   = sync || init_q;
    load_mode = decode_mode(cfg_mode);
    ready_d   = !accept;
    err_d     = accept && cfg_bad;
    init_d    = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      init_q  <= 1'b1;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      init_q  <= init_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    tick_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart   (restart),
      .load      (load_ok && (cfg_ch == 4'(gi))),
      .load_mode (load_mode),
      .load_div  (cfg_div),
      .tick      (tick[gi]),
      .busy      (busy[gi])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed self-checking bench for tick_gen_multi with a 10-cycle default period.
// cyc counts cycles after the first edge with rst_n=1; outputs are sampled 1 ns after each edge.
module tb_tick_gen_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_ch = 4'd0;
  logic [7:0] cfg_div = 8'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [3:0] tick;
  logic [3:0] busy;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [3:0] et, eb;

  always #5 clk = ~clk;

  tick_gen_multi #(
    .CLK_FREQ  (100),
    .OUT_FREQ  (10),
    .NUM_CH    (4),
    .DIV_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .tick      (tick),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs(input logic [3:0] t, input logic [3:0] b, input logic r, input logic e);
    chk("tick", 32'(tick), 32'(t));
    chk("busy", 32'(busy), 32'(b));
    chk("cfg_ready", 32'(cfg_ready), 32'(r));
    chk("cfg_err", 32'(cfg_err), 32'(e));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) step();
    check_outs(4'h0, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic drive_cfg(input int ch, input int div, input int mode);
    cfg_valid = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_div   = 8'(div);
    cfg_mode  = 2'(mode);
    $display("cfg request cyc=%0d ch=%0d div=%0d mode=%0d", cyc, ch, div, mode);
  endtask

  function automatic logic [3:0] every10(input int c);
    return (c % 10 == 0) ? 4'hF : 4'h0;
  endfunction

  initial begin
    // Default period after release: ticks in cycles 10, 20, 30.
    do_reset();
    for (int c = 1; c <= 31; c++) begin
      step();
      check_outs(every10(cyc), 4'h0, 1'b1, 1'b0);
    end
    $display("done: default periodic ticks");

    // ch1 PERIODIC div=3 accepted at edge 2; valid held one extra cycle while not ready.
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      step();
      et    = every10(cyc) & 4'b1101;
      et[1] = (cyc > 2) && ((cyc - 2) % 3 == 0);
      check_outs(et, 4'h0, cyc != 3, 1'b0);
      if (cyc == 2) drive_cfg(1, 3, 1);
      else if (cyc == 4) cfg_valid = 1'b0;
    end
    $display("done: ch1 periodic div=3");

    // ch2 ONESHOT div=5 at edge 2: busy cycles 3..6, single tick in cycle 7.
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      step();
      et    = every10(cyc) & 4'b1011;
      et[2] = (cyc == 7);
      eb    = 4'h0;
      eb[2] = (cyc >= 3) && (cyc <= 6);
      check_outs(et, eb, cyc != 3, 1'b0);
      if (cyc == 2) drive_cfg(2, 5, 2);
      else if (cyc == 3) cfg_valid = 1'b0;
    end
    $display("done: ch2 oneshot div=5");

    // Rejected requests: channel 7, then div=0 on ch0.
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      step();
      check_outs(every10(cyc), 4'h0, !(cyc == 3 || cyc == 5), (cyc == 3 || cyc == 5));
      if (cyc == 2) drive_cfg(7, 3, 1);
      else if (cyc == 3) cfg_valid = 1'b0;
      else if (cyc == 4) drive_cfg(0, 0, 1);
      else if (cyc == 5) cfg_valid = 1'b0;
    end
    $display("done: rejected requests");

    // sync at edge 4: next ticks in cycles 14 and 24.
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      step();
      check_outs((cyc == 14 || cyc == 24) ? 4'hF : 4'h0, 4'h0, 1'b1, 1'b0);
      if (cyc == 4) sync = 1'b1;
      else if (cyc == 5) sync = 1'b0;
    end
    $display("done: sync");

    // sync together with ch0 div=2 accept at edge 4.
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      step();
      et    = (cyc == 14 || cyc == 24) ? 4'hE : 4'h0;
      et[0] = (cyc > 4) && (cyc % 2 == 0);
      check_outs(et, 4'h0, cyc != 5, 1'b0);
      if (cyc == 4) begin
        sync = 1'b1;
        drive_cfg(0, 2, 1);
      end else if (cyc == 5) begin
        sync      = 1'b0;
        cfg_valid = 1'b0;
      end
    end
    $display("done: sync plus accept");

    // ch3 ONESHOT div=20, reset for edges 8..10: no ch3 pulse, all restart from edge 11.
    do_reset();
    for (int c = 1; c <= 35; c++) begin
      step();
      et    = (cyc == 21 || cyc == 31) ? 4'hF : 4'h0;
      eb    = 4'h0;
      eb[3] = (cyc >= 3) && (cyc <= 8);
      check_outs(et, eb, cyc != 3, 1'b0);
      if (cyc == 2) drive_cfg(3, 20, 2);
      else if (cyc == 3) cfg_valid = 1'b0;
      else if (cyc == 8) rst_n = 1'b0;
      else if (cyc == 11) rst_n = 1'b1;
    end
    $display("done: reset during oneshot");

    // ch0 div=1 ticks every cycle after its load; ch1 reserved mode behaves as OFF.
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      step();
      et    = every10(cyc) & 4'b1100;
      et[0] = (cyc >= 4);
      check_outs(et, 4'h0, !(cyc == 3 || cyc == 5), 1'b0);
      if (cyc == 2) drive_cfg(0, 1, 1);
      else if (cyc == 3) cfg_valid = 1'b0;
      else if (cyc == 4) drive_cfg(1, 5, 3);
      else if (cyc == 5) cfg_valid = 1'b0;
    end
    $display("done: div=1 and reserved mode");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
